// File: rtl/rx_cpl_host_mem_pkg.sv
// Shared TLP fmt_type codes, receive FSM state encodings and completion-decode helpers
// for the host-memory completion receiver.
package rx_cpl_host_mem_pkg;

    localparam logic [6:0] MRD32_FMT_TYPE = 7'b00_00000;
    localparam logic [6:0] MRD64_FMT_TYPE = 7'b01_00000;
    localparam logic [6:0] MWR32_FMT_TYPE = 7'b10_00000;
    localparam logic [6:0] MWR64_FMT_TYPE = 7'b11_00000;
    localparam logic [6:0] CPLD_FMT_TYPE  = 7'b10_01010;
    localparam logic [6:0] CPL_FMT_TYPE   = 7'b00_01010;

    localparam logic [2:0] CPL_STATUS_SC  = 3'b000;
    localparam logic [7:0] RREM_UPPER_DW  = 8'h0F;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_HDR2 = 4'b0010,
        ST_DATA = 4'b0100,
        ST_DROP = 4'b1000
    } rx_state_e;

    typedef enum logic [1:0] {
        TLP_CPLD  = 2'd0,
        TLP_CPL   = 2'd1,
        TLP_MEM   = 2'd2,
        TLP_OTHER = 2'd3
    } tlp_kind_e;

    function automatic tlp_kind_e classify_tlp(input logic [6:0] fmt_type);
        tlp_kind_e kind;
        case (fmt_type)
            CPLD_FMT_TYPE:  kind = TLP_CPLD;
            CPL_FMT_TYPE:   kind = TLP_CPL;
            MRD32_FMT_TYPE,
            MRD64_FMT_TYPE,
            MWR32_FMT_TYPE,
            MWR64_FMT_TYPE: kind = TLP_MEM;
            default:        kind = TLP_OTHER;
        endcase
        return kind;
    endfunction

    // Remaining byte count equal to this TLP's payload means it closes the request;
    // length 0 (1024 DW) and byte_count 0 (4096 B) line up naturally.
    function automatic logic is_last_cpl(input logic [11:0] byte_count,
                                         input logic [9:0]  length);
        return (byte_count == {length, 2'b00});
    endfunction

endpackage

// File: rtl/rx_cpl_host_mem_if.sv
// TRN receive bus between the PCIe core (master) and the completion receiver (slave).
interface rx_cpl_host_mem_if;

    logic [63:0] trn_rd;
    logic [7:0]  trn_rrem_n;
    logic        trn_rsof_n;
    logic        trn_reof_n;
    logic        trn_rsrc_rdy_n;
    logic        trn_rdst_rdy_n;
    logic        trn_rerrfwd_n;
    logic        trn_rnp_ok_n;

    modport master (
        output trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rerrfwd_n,
        input  trn_rdst_rdy_n, trn_rnp_ok_n
    );

    modport slave (
        input  trn_rd, trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rerrfwd_n,
        output trn_rdst_rdy_n, trn_rnp_ok_n
    );

endinterface

// File: rtl/rx_cpl_host_mem_cpl_tag_offset.sv
// Per-tag qword write offset: 16 entries, combinational read, increment and clear.
// A clear on the same cycle as an increment wins.
module cpl_tag_offset #(
    parameter int ADDR_W = 13
) (
    input  logic              trn_clk,
    input  logic              reset_n,
    input  logic [3:0]        rd_tag,
    input  logic              inc,
    input  logic              clr,
    input  logic [3:0]        clr_tag,
    output logic [ADDR_W-5:0] rd_off
);

    localparam int OFF_W = ADDR_W - 4;

    logic [OFF_W-1:0] off_r [16];

    // Offset register file update
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                off_r[i] <= {OFF_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (clr && (clr_tag == 4'(i))) begin
                    off_r[i] <= {OFF_W{1'b0}};
                end else if (inc && (rd_tag == 4'(i))) begin
                    off_r[i] <= off_r[i] + {{(OFF_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign rd_off = off_r[rd_tag];

endmodule

// File: rtl/rx_cpl_host_mem.sv
// CplD receiver for our MRd64 requests: realigns 3DW-header payload into qwords,
// writes them into the buffer slot of the tag and flags request completion or errors.
module rx_cpl_host_mem
    import rx_cpl_host_mem_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic               trn_clk,
    input  logic               reset_n,
    rx_cpl_host_mem_if.slave   trn,
    input  logic [15:0]        cfg_completer_id,
    input  logic               buf_wr_rdy,
    output logic               buf_wr_en,
    output logic [ADDR_W-1:0]  buf_wr_addr,
    output logic [63:0]        buf_wr_data,
    output logic               cpl_done,
    output logic [3:0]         cpl_done_tag,
    output logic               cpl_err
);

    localparam int OFF_W = ADDR_W - 4;

    rx_state_e        state_r;
    logic [3:0]       tag_r;
    logic [31:0]      carry_r;
    logic             last_r;
    logic             drop_err_r;
    logic             drop_first_r;

    logic             accept_s;
    logic             sof_s;
    logic             eof_s;
    logic             poison_s;
    logic             id_ok_s;
    logic             rrem_ok_s;
    logic             drop_keep_err_s;
    tlp_kind_e        kind_s;
    logic             wr_s;
    logic             clr_s;
    logic [3:0]       clr_tag_s;
    logic [OFF_W-1:0] off_s;

    assign trn.trn_rdst_rdy_n = ~(buf_wr_rdy & reset_n);
    assign trn.trn_rnp_ok_n   = 1'b0;

    assign accept_s  = ~trn.trn_rsrc_rdy_n & ~trn.trn_rdst_rdy_n;
    assign sof_s     = ~trn.trn_rsof_n;
    assign eof_s     = ~trn.trn_reof_n;
    assign poison_s  = ~trn.trn_rerrfwd_n;
    assign id_ok_s   = (trn.trn_rd[63:48] == cfg_completer_id);
    assign rrem_ok_s = (trn.trn_rrem_n == RREM_UPPER_DW);
    assign kind_s    = classify_tlp(trn.trn_rd[62:56]);

    // A dropped bad completion whose DW2 names another requester is not ours: stay silent.
    assign drop_keep_err_s = drop_err_r & ~(drop_first_r & ~id_ok_s);

    // Per-beat write and offset-clear decisions
    always_comb begin
        wr_s      = 1'b0;
        clr_s     = 1'b0;
        clr_tag_s = tag_r;
        if (accept_s) begin
            case (state_r)
                ST_HDR2: begin
                    clr_tag_s = trn.trn_rd[43:40];
                    clr_s     = id_ok_s & (eof_s | poison_s);
                end
                ST_DATA: begin
                    if (poison_s || (eof_s && !rrem_ok_s)) begin
                        clr_s = 1'b1;
                    end else begin
                        wr_s  = 1'b1;
                        clr_s = eof_s & last_r;
                    end
                end
                ST_DROP: begin
                    clr_tag_s = trn.trn_rd[43:40];
                    clr_s     = drop_first_r & drop_err_r & id_ok_s;
                end
                default: begin
                    wr_s  = 1'b0;
                    clr_s = 1'b0;
                end
            endcase
        end else begin
            wr_s  = 1'b0;
            clr_s = 1'b0;
        end
    end

    cpl_tag_offset #(
        .ADDR_W (ADDR_W)
    ) u_cpl_tag_offset (
        .trn_clk (trn_clk),
        .reset_n (reset_n),
        .rd_tag  (tag_r),
        .inc     (wr_s),
        .clr     (clr_s),
        .clr_tag (clr_tag_s),
        .rd_off  (off_s)
    );

    // Receive FSM with registered write port and status pulses
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            tag_r        <= 4'd0;
            carry_r      <= 32'd0;
            last_r       <= 1'b0;
            drop_err_r   <= 1'b0;
            drop_first_r <= 1'b0;
            buf_wr_en    <= 1'b0;
            buf_wr_addr  <= {ADDR_W{1'b0}};
            buf_wr_data  <= 64'd0;
            cpl_done     <= 1'b0;
            cpl_done_tag <= 4'd0;
            cpl_err      <= 1'b0;
        end else begin
            buf_wr_en <= wr_s;
            cpl_done  <= 1'b0;
            cpl_err   <= 1'b0;
            if (wr_s) begin
                buf_wr_addr <= {tag_r, off_s};
                buf_wr_data <= {trn.trn_rd[63:32], carry_r};
            end
            if (accept_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (sof_s) begin
                            last_r       <= is_last_cpl(trn.trn_rd[11:0], trn.trn_rd[41:32]);
                            drop_first_r <= 1'b1;
                            if (eof_s) begin
                                state_r <= ST_IDLE;
                            end else if ((kind_s == TLP_CPLD) &&
                                         (trn.trn_rd[15:13] == CPL_STATUS_SC) && !poison_s) begin
                                drop_err_r <= 1'b0;
                                state_r    <= ST_HDR2;
                            end else if ((kind_s == TLP_CPLD) || (kind_s == TLP_CPL)) begin
                                drop_err_r <= 1'b1;
                                state_r    <= ST_DROP;
                            end else begin
                                drop_err_r <= 1'b0;
                                state_r    <= ST_DROP;
                            end
                        end
                    end
                    ST_HDR2: begin
                        if (!id_ok_s) begin
                            drop_err_r   <= 1'b0;
                            drop_first_r <= 1'b0;
                            state_r      <= eof_s ? ST_IDLE : ST_DROP;
                        end else begin
                            tag_r   <= trn.trn_rd[43:40];
                            carry_r <= trn.trn_rd[31:0];
                            if (eof_s) begin
                                cpl_err <= 1'b1;
                                state_r <= ST_IDLE;
                            end else if (poison_s) begin
                                drop_err_r   <= 1'b1;
                                drop_first_r <= 1'b0;
                                state_r      <= ST_DROP;
                            end else begin
                                state_r <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        carry_r <= trn.trn_rd[31:0];
                        if (poison_s) begin
                            if (eof_s) begin
                                cpl_err <= 1'b1;
                                state_r <= ST_IDLE;
                            end else begin
                                drop_err_r   <= 1'b1;
                                drop_first_r <= 1'b0;
                                state_r      <= ST_DROP;
                            end
                        end else if (eof_s) begin
                            state_r <= ST_IDLE;
                            if (rrem_ok_s) begin
                                cpl_done <= last_r;
                                if (last_r) begin
                                    cpl_done_tag <= tag_r;
                                end
                            end else begin
                                cpl_err <= 1'b1;
                            end
                        end
                    end
                    ST_DROP: begin
                        drop_first_r <= 1'b0;
                        drop_err_r   <= drop_keep_err_s;
                        if (eof_s) begin
                            cpl_err <= drop_keep_err_s;
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_cpl_host_mem.sv
// Directed bench for rx_cpl_host_mem: hand-built completions, expected qwords and
// addresses computed from the DW numbering of each stimulus.
module tb_rx_cpl_host_mem;
    import rx_cpl_host_mem_pkg::*;

    localparam int          ADDR_W = 13;
    localparam logic [15:0] OUR_ID = 16'h0100;

    logic              trn_clk = 1'b0;
    logic              reset_n;
    logic [15:0]       cfg_completer_id;
    logic              buf_wr_rdy;
    logic              buf_wr_en;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic [63:0]       buf_wr_data;
    logic              cpl_done;
    logic [3:0]        cpl_done_tag;
    logic              cpl_err;

    rx_cpl_host_mem_if rx ();

    rx_cpl_host_mem #(.ADDR_W(ADDR_W)) dut (
        .trn_clk          (trn_clk),
        .reset_n          (reset_n),
        .trn              (rx.slave),
        .cfg_completer_id (cfg_completer_id),
        .buf_wr_rdy       (buf_wr_rdy),
        .buf_wr_en        (buf_wr_en),
        .buf_wr_addr      (buf_wr_addr),
        .buf_wr_data      (buf_wr_data),
        .cpl_done         (cpl_done),
        .cpl_done_tag     (cpl_done_tag),
        .cpl_err          (cpl_err)
    );

    always #5 trn_clk = ~trn_clk;

    int   checks = 0;
    int   errors = 0;
    logic rand_rdy = 1'b0;
    logic poison_beat = 1'b0;

    logic [ADDR_W-1:0] wa_q [$];
    logic [63:0]       wd_q [$];
    int                done_n = 0;
    int                err_n = 0;
    logic [3:0]        done_tag_c = 4'd0;
    logic              done_wr_c = 1'b0;
    logic [ADDR_W-1:0] done_addr_c = '0;

    // Log every registered write and pulse
    always @(posedge trn_clk) begin
        if (buf_wr_en) begin
            wa_q.push_back(buf_wr_addr);
            wd_q.push_back(buf_wr_data);
        end
        if (cpl_done) begin
            done_n      <= done_n + 1;
            done_tag_c  <= cpl_done_tag;
            done_wr_c   <= buf_wr_en;
            done_addr_c <= buf_wr_addr;
        end
        if (cpl_err) begin
            err_n <= err_n + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {63'd0, obs}, {63'd0, exp});
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        chk(tag, 64'(obs), 64'(exp));
    endtask

    function automatic logic [ADDR_W-1:0] ea(input logic [3:0] t, input int o);
        logic [8:0] o9;
        o9 = o[8:0];
        return {t, o9};
    endfunction

    function automatic logic [63:0] ed(input logic [31:0] base, input int i);
        return {base + 32'(2*i+1), base + 32'(2*i)};
    endfunction

    task automatic chk_wr(input string tag, input int idx, input logic [ADDR_W-1:0] a,
                          input logic [63:0] d);
        logic [63:0] oa;
        logic [63:0] od;
        oa = {64{1'b1}};
        od = {64{1'b1}};
        if (idx < wa_q.size()) begin
            oa = 64'(wa_q[idx]);
            od = wd_q[idx];
        end
        chk({tag, "_addr"}, oa, {51'd0, a});
        chk({tag, "_data"}, od, d);
    endtask

    task automatic idle(input int n);
        rx.trn_rsrc_rdy_n = 1'b1;
        rx.trn_rsof_n     = 1'b1;
        rx.trn_reof_n     = 1'b1;
        rx.trn_rerrfwd_n  = 1'b1;
        repeat (n) @(negedge trn_clk);
    endtask

    // Present one beat from a negedge and hold it until accepted (bounded).
    task automatic beat(input logic [63:0] d, input logic [7:0] rrem, input logic sof,
                        input logic eof);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        rx.trn_rd         = d;
        rx.trn_rrem_n     = rrem;
        rx.trn_rsof_n     = ~sof;
        rx.trn_reof_n     = ~eof;
        rx.trn_rerrfwd_n  = ~poison_beat;
        rx.trn_rsrc_rdy_n = 1'b0;
        while (!acc && n < 64) begin
            if (rand_rdy) begin
                buf_wr_rdy = 1'($urandom_range(0, 1));
                #1;
                chk1("rdy_mirror", rx.trn_rdst_rdy_n, ~buf_wr_rdy);
            end
            @(posedge trn_clk);
            acc = ~rx.trn_rdst_rdy_n;
            @(negedge trn_clk);
            n++;
        end
        chk1("beat_accept", acc, 1'b1);
    endtask

    // CplD of ndw DWs (even), data DWj = base + j; sends nbeats of its data beats.
    task automatic send_cpld(input logic [3:0] tag, input int ndw, input logic [11:0] bc,
                             input logic [2:0] st, input logic [15:0] rid,
                             input logic [31:0] base, input int nbeats, input int pois_idx);
        logic [31:0] dw0, dw1, dw2, hi, lo;
        logic [9:0]  len;
        logic        last;
        len = ndw[9:0];
        dw0 = {1'b0, CPLD_FMT_TYPE, 14'd0, len};
        dw1 = {16'hBEEF, st, 1'b0, bc};
        dw2 = {rid, 4'h0, tag, 1'b0, 7'd0};
        poison_beat = 1'b0;
        beat({dw0, dw1}, 8'h00, 1'b1, 1'b0);
        beat({dw2, base}, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < nbeats; i++) begin
            last = (i == ndw/2 - 1);
            hi   = base + 32'(2*i+1);
            lo   = last ? 32'd0 : base + 32'(2*i+2);
            poison_beat = (i == pois_idx);
            beat({hi, lo}, last ? 8'h0F : 8'h00, 1'b0, last);
        end
        poison_beat = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_wr_en"}, buf_wr_en, 1'b0);
        chk({tag, "_wr_addr"}, {51'd0, buf_wr_addr}, 64'd0);
        chk({tag, "_wr_data"}, buf_wr_data, 64'd0);
        chk1({tag, "_done"}, cpl_done, 1'b0);
        chk({tag, "_done_tag"}, {60'd0, cpl_done_tag}, 64'd0);
        chk1({tag, "_err"}, cpl_err, 1'b0);
        chk1({tag, "_dst_rdy_n"}, rx.trn_rdst_rdy_n, 1'b1);
        chk1({tag, "_np_ok_n"}, rx.trn_rnp_ok_n, 1'b0);
    endtask

    initial begin
        int b;
        int d0;
        int e0;
        reset_n           = 1'b0;
        buf_wr_rdy        = 1'b1;
        cfg_completer_id  = OUR_ID;
        rx.trn_rd         = 64'd0;
        rx.trn_rrem_n     = 8'h00;
        idle(3);
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        idle(2);

        // 1: tag 3, 4 DW, last completion
        b = wa_q.size(); d0 = done_n;
        send_cpld(4'd3, 4, 12'd16, 3'b000, OUR_ID, 32'h0000_00A0, 2, -1);
        chk1("t1_wr_en_lat", buf_wr_en, 1'b1);
        chk1("t1_done_with_wr", cpl_done, 1'b1);
        chk({"t1_done_tag"}, {60'd0, cpl_done_tag}, 64'd3);
        idle(3);
        chk_int("t1_nwr", wa_q.size() - b, 2);
        chk_wr("t1_w0", b,     13'h0600, {32'h0000_00A1, 32'h0000_00A0});
        chk_wr("t1_w1", b + 1, 13'h0601, {32'h0000_00A3, 32'h0000_00A2});
        chk_int("t1_ndone", done_n - d0, 1);
        chk({"t1_done_addr"}, {51'd0, done_addr_c}, {51'd0, 13'h0601});

        // 2: tag 5, 128 DW as two 64-DW completions
        b = wa_q.size(); d0 = done_n;
        send_cpld(4'd5, 64, 12'd512, 3'b000, OUR_ID, 32'h1000_0000, 32, -1);
        send_cpld(4'd5, 64, 12'd256, 3'b000, OUR_ID, 32'h2000_0000, 32, -1);
        idle(3);
        chk_int("t2_nwr", wa_q.size() - b, 64);
        for (int i = 0; i < 64; i++) begin
            chk_wr("t2_w", b + i, ea(4'd5, i),
                   (i < 32) ? ed(32'h1000_0000, i) : ed(32'h2000_0000, i - 32));
        end
        chk_int("t2_ndone", done_n - d0, 1);
        chk({"t2_done_addr"}, {51'd0, done_addr_c}, {51'd0, ea(4'd5, 63)});
        chk({"t2_done_tag"}, {60'd0, done_tag_c}, 64'd5);
        chk1("t2_done_wr", done_wr_c, 1'b1);
        b = wa_q.size();
        send_cpld(4'd5, 2, 12'd8, 3'b000, OUR_ID, 32'h0000_5550, 1, -1);
        idle(3);
        chk_int("t2_off_nwr", wa_q.size() - b, 1);
        chk_wr("t2_off0", b, ea(4'd5, 0), ed(32'h0000_5550, 0));

        // 3: tag 7, unsuccessful status clears the offset
        b = wa_q.size(); d0 = done_n;
        send_cpld(4'd7, 2, 12'd16, 3'b000, OUR_ID, 32'h0000_7700, 1, -1);
        idle(3);
        chk_wr("t3_pre", b, ea(4'd7, 0), ed(32'h0000_7700, 0));
        b = wa_q.size(); e0 = err_n;
        send_cpld(4'd7, 2, 12'd8, 3'b001, OUR_ID, 32'h0000_7710, 1, -1);
        idle(3);
        chk_int("t3_ur_nwr", wa_q.size() - b, 0);
        chk_int("t3_ur_err", err_n - e0, 1);
        send_cpld(4'd7, 2, 12'd8, 3'b000, OUR_ID, 32'h0000_7720, 1, -1);
        idle(3);
        chk_wr("t3_off0", b, ea(4'd7, 0), ed(32'h0000_7720, 0));
        chk_int("t3_ndone", done_n - d0, 1);

        // 4: ID mismatch, MWr, then a valid CplD all back-to-back
        b = wa_q.size(); d0 = done_n; e0 = err_n;
        send_cpld(4'd9, 4, 12'd16, 3'b000, 16'h0200, 32'h0000_9900, 2, -1);
        beat({1'b0, MWR64_FMT_TYPE, 14'd0, 10'd2, OUR_ID, 8'h09, 8'hFF}, 8'h00, 1'b1, 1'b0);
        beat({32'h0000_0000, 32'h0001_0000}, 8'h00, 1'b0, 1'b0);
        beat({32'hDEAD_0000, 32'hDEAD_0001}, 8'h00, 1'b0, 1'b1);
        send_cpld(4'd9, 2, 12'd8, 3'b000, OUR_ID, 32'h0000_9930, 1, -1);
        idle(3);
        chk_int("t4_nwr", wa_q.size() - b, 1);
        chk_wr("t4_w0", b, ea(4'd9, 0), ed(32'h0000_9930, 0));
        chk_int("t4_nerr", err_n - e0, 0);
        chk_int("t4_ndone", done_n - d0, 1);

        // 5: buf_wr_rdy toggled randomly, 32 DW on tag 11
        b = wa_q.size(); d0 = done_n;
        rand_rdy = 1'b1;
        send_cpld(4'd11, 32, 12'd128, 3'b000, OUR_ID, 32'hB000_0000, 16, -1);
        rand_rdy   = 1'b0;
        buf_wr_rdy = 1'b1;
        idle(3);
        chk_int("t5_nwr", wa_q.size() - b, 16);
        for (int i = 0; i < 16; i++) begin
            chk_wr("t5_w", b + i, ea(4'd11, i), ed(32'hB000_0000, i));
        end
        chk_int("t5_ndone", done_n - d0, 1);

        // Poison on the final beat of a tag 4 completion
        b = wa_q.size(); d0 = done_n; e0 = err_n;
        send_cpld(4'd4, 4, 12'd16, 3'b000, OUR_ID, 32'h0000_4400, 2, 1);
        idle(3);
        chk_int("tp_nwr", wa_q.size() - b, 1);
        chk_wr("tp_w0", b, ea(4'd4, 0), ed(32'h0000_4400, 0));
        chk_int("tp_nerr", err_n - e0, 1);
        chk_int("tp_ndone", done_n - d0, 0);
        b = wa_q.size();
        send_cpld(4'd4, 2, 12'd8, 3'b000, OUR_ID, 32'h0000_4410, 1, -1);
        idle(3);
        chk_wr("tp_off0", b, ea(4'd4, 0), ed(32'h0000_4410, 0));

        // 6: reset in the middle of a tag 2 completion
        b = wa_q.size();
        send_cpld(4'd2, 8, 12'd32, 3'b000, OUR_ID, 32'h0000_2200, 2, -1);
        idle(2);
        chk_int("t6_pre_nwr", wa_q.size() - b, 2);
        chk_wr("t6_pre_w1", b + 1, ea(4'd2, 1), ed(32'h0000_2200, 1));
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("t6_rst");
        @(negedge trn_clk);
        reset_n = 1'b1;
        @(negedge trn_clk);
        b = wa_q.size(); e0 = err_n;
        beat({32'h0000_2205, 32'h0000_2206}, 8'h00, 1'b0, 1'b0);
        beat({32'h0000_2207, 32'h0000_0000}, 8'h0F, 1'b0, 1'b1);
        send_cpld(4'd2, 2, 12'd8, 3'b000, OUR_ID, 32'h0000_2290, 1, -1);
        idle(3);
        chk_int("t6_nwr", wa_q.size() - b, 1);
        chk_wr("t6_off0", b, ea(4'd2, 0), ed(32'h0000_2290, 0));
        chk_int("t6_nerr", err_n - e0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
